// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encodings and constants for pipeline stage registers
package pipe_pkg;

    // Stage occupancy: EMPTY holds nothing, FULL holds one beat in main,
    // SKID holds a second beat parked in the skid register behind main.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_e;

    // All-zero word decodes as sll $0,$0,0, i.e. a NOP bubble for instruction stages.
    localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

endpackage

// File: rtl/pipe_dreg.sv
// rtl/pipe_dreg.sv - load-enabled data register with async reset and sync clear
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset (q <= RESET_VAL)
//   clr         synchronous clear to RESET_VAL, wins over load
//   load        capture d on the next rising edge
//   d, q        WIDTH-bit data in / registered data out
module pipe_dreg
    import pipe_pkg::*;
#(
    parameter int unsigned              WIDTH     = 32,
    parameter logic [WIDTH-1:0]         RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else if (clr) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - valid/ready pipeline register stage with 2-entry skid buffer and flush
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   flush                 synchronous kill of held and incoming beats
//   in_valid/in_ready     upstream handshake; in_ready comes from the state register only
//   in_data               upstream payload
//   out_valid/out_ready   downstream handshake; out_valid comes from the state register only
//   out_data              payload, always the main register
//   stall_cnt             saturating count of out_valid & !out_ready cycles
// Build option: PIPE_STAGE_STALL_CNT_EN enables the stall counter; otherwise stall_cnt is 0.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int unsigned      CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt
);

    pipe_state_e      state_q;
    pipe_state_e      state_d;
    logic             accept;
    logic             fire;
    logic             main_load;
    logic             main_from_skid;
    logic             skid_load;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    // Both handshake outputs depend on state only, so a downstream stall
    // reaches upstream one cycle late; the skid entry absorbs that beat.
    assign in_ready  = (state_q != ST_SKID);
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;

    assign accept = in_valid & in_ready;
    assign fire   = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;

        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_load = 1'b1;
                    state_d   = ST_FULL;
                end
            end
            ST_FULL: begin
                if (accept && fire) begin
                    main_load = 1'b1;
                end else if (accept) begin
                    skid_load = 1'b1;
                    state_d   = ST_SKID;
                end else if (fire) begin
                    // main keeps the delivered beat; out_valid alone marks it dead
                    state_d = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (fire) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    state_d        = ST_FULL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // Flush overrides every handshake outcome; the registers are cleared
        // through their clr inputs, so the loads are simply suppressed here.
        if (flush) begin
            state_d        = ST_EMPTY;
            main_load      = 1'b0;
            main_from_skid = 1'b0;
            skid_load      = 1'b0;
        end
    end

    assign main_d = main_from_skid ? skid_q : in_data;

    pipe_dreg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .load  (main_load),
        .d     (main_d),
        .q     (main_q)
    );

    pipe_dreg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .load  (skid_load),
        .d     (in_data),
        .q     (skid_q)
    );

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    // Cleared by reset only; a flush cycle still counts if the stall condition holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage.sv
// tb/tb_pipe_stage.sv - directed self-checking bench for pipe_stage
module tb_pipe_stage;

    localparam int unsigned      W    = 32;
    localparam int unsigned      CW   = 4;
    localparam logic [W-1:0]     RV   = 32'hCAFE_0013;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] stall_cnt;

    int n_checks;
    int n_fail;

    pipe_stage #(
        .WIDTH     (W),
        .RESET_VAL (RV),
        .CNT_W     (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hDEAD_BEEF;
        out_ready = 1'b0;
        step();
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL reset_out_valid got=%b exp=0", out_valid); n_fail++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_in_ready got=%b exp=1", in_ready); n_fail++;
        end
        n_checks++;
        if (out_data !== RV) begin
            $display("FAIL reset_out_data got=%h exp=%h", out_data, RV); n_fail++;
        end
        n_checks++;
        if (stall_cnt !== 4'd0) begin
            $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); n_fail++;
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hDEAD_BEEF) begin
            $display("FAIL first_beat got=%b/%h exp=1/deadbeef", out_valid, out_data); n_fail++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 32'hDEAD_BEEF) begin
            $display("FAIL drain_hold got=%b/%h exp=0/deadbeef", out_valid, out_data); n_fail++;
        end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data  = W'(i);
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== W'(i) || in_ready !== 1'b1) begin
                $display("FAIL stream_%0d got v=%b d=%h r=%b exp v=1 d=%h r=1",
                         i, out_valid, out_data, in_ready, W'(i));
                n_fail++;
            end
        end
        in_valid = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL stream_drain got=%b exp=0", out_valid); n_fail++;
        end
    endtask

    task automatic test_skid();
        in_valid  = 1'b1;
        in_data   = 32'd5;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_data   = 32'd6;
        step();
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'd5) begin
            $display("FAIL skid_enter got r=%b v=%b d=%h exp r=0 v=1 d=5", in_ready, out_valid, out_data);
            n_fail++;
        end
        in_data = 32'd99;
        step();
        n_checks++;
        if (in_ready !== 1'b0 || out_data !== 32'd5) begin
            $display("FAIL skid_hold got r=%b d=%h exp r=0 d=5", in_ready, out_data); n_fail++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'd6 || in_ready !== 1'b1) begin
            $display("FAIL skid_second got v=%b d=%h r=%b exp v=1 d=6 r=1", out_valid, out_data, in_ready);
            n_fail++;
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL skid_drain got=%b exp=0 (99 must not appear)", out_valid); n_fail++;
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'd7;
        step();
        in_data = 32'd8;
        step();
        n_checks++;
        if (in_ready !== 1'b0 || out_data !== 32'd7) begin
            $display("FAIL flush_setup got r=%b d=%h exp r=0 d=7", in_ready, out_data); n_fail++;
        end
        flush   = 1'b1;
        in_data = 32'd9;
        step();
        flush = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== RV) begin
            $display("FAIL flush_state got v=%b r=%b d=%h exp v=0 r=1 d=%h", out_valid, in_ready, out_data, RV);
            n_fail++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b0 || out_data !== RV) begin
                $display("FAIL flush_after_%0d got v=%b d=%h exp v=0 d=%h", i, out_valid, out_data, RV);
                n_fail++;
            end
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h0000_1234;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h0000_1234) begin
            $display("FAIL areset_setup got v=%b d=%h exp v=1 d=1234", out_valid, out_data); n_fail++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== RV || stall_cnt !== 4'd0) begin
            $display("FAIL areset_now got v=%b r=%b d=%h s=%0d exp v=0 r=1 d=%h s=0",
                     out_valid, in_ready, out_data, stall_cnt, RV);
            n_fail++;
        end
        #2;
        rst_n = 1'b1;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== RV) begin
            $display("FAIL areset_release got v=%b d=%h exp v=0 d=%h", out_valid, out_data, RV); n_fail++;
        end
    endtask

    task automatic test_stall_cnt();
        logic [CW-1:0] exp_cnt;
        rst_n = 1'b0;
        step();
        rst_n     = 1'b1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h0000_0042;
        step();
        in_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
`ifdef PIPE_STAGE_STALL_CNT_EN
            exp_cnt = (i > 15) ? 4'd15 : CW'(i);
`else
            exp_cnt = 4'd0;
`endif
            n_checks++;
            if (stall_cnt !== exp_cnt) begin
                $display("FAIL stall_cnt_%0d got=%0d exp=%0d", i, stall_cnt, exp_cnt); n_fail++;
            end
        end
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h0000_0042) begin
            $display("FAIL stall_hold got v=%b d=%h exp v=1 d=42", out_valid, out_data); n_fail++;
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_streaming();
        test_skid();
        test_flush();
        test_async_reset();
        test_stall_cnt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage.md
Name: pipe_stage

Overview:
Parametrised pipeline register stage for the MIPS datapath. It is the generalised successor of the plain enable-gated 32-bit stage register.
- Adds valid/ready handshake, a 2-entry skid buffer, synchronous flush (bubble insertion) and a programmable reset/bubble value.
- Sits between pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Breaks the combinational ready path: a downstream stall never reaches upstream in the same cycle.

Parameters:
- WIDTH, 32, payload width in bits (>=1).
- RESET_VAL, {WIDTH{1'b0}}, value loaded into the data registers on reset and on flush (a NOP encoding when used as the instruction register).
- CNT_W, 16, width of the optional stall counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous kill of all held and incoming data.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  stage can accept; driven only from state register.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  out_data holds a live beat.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  payload; driven from main register only.
- stall_cnt  output  CNT_W  stall cycles seen (optional feature; otherwise 0).

Behaviour:
- Reset, flush and ready:
  - One clock; reset is asynchronous and active-low (clk, rst_n). On rst_n=0: state=EMPTY, main=skid=RESET_VAL, out_valid=0, in_ready=1, stall_cnt=0.
  - Handshakes: accept = in_valid & in_ready; fire = out_valid & out_ready.
  - in_ready = (state != SKID); out_valid = (state != EMPTY); out_data = main. No combinational path from inputs to outputs.
- States and transitions (flush=0):
  - EMPTY: accept -> main<=in_data, FULL. Otherwise stay.
  - FULL, accept & fire: main<=in_data, stay FULL (1 beat/cycle throughput).
  - FULL, accept & !fire: skid<=in_data, go to SKID.
  - FULL, !accept & fire: go to EMPTY; main holds its last value.
  - FULL, neither: hold.
  - SKID (in_ready=0, in_valid ignored), fire: main<=skid, go to FULL.
  - SKID, no fire: hold.
- Latency and ordering:
  - Latency: 1 cycle from accept to out_valid when the stage is empty.
  - Strict FIFO order; no beat dropped or duplicated except by flush.
- Flush (synchronous, priority over all handshakes):
  - Next state EMPTY; main and skid <= RESET_VAL.
  - A beat accepted in the flush cycle is discarded.
  - A fire in the flush cycle still counts as delivered downstream.
  - in_ready=1 in the cycle after a flush.
- Reset mid-operation: immediate return to reset values regardless of state or handshakes.
- Data registers are written only on the transitions listed; otherwise they hold. This preserves the stall behaviour of the original enable register.
- Illegal state encoding (3): recovers to EMPTY on the next clock.

Optional Feature:
- Macro PIPE_STAGE_STALL_CNT_EN.
- Defined: stall_cnt increments by 1 each cycle with out_valid=1 & out_ready=0. It saturates at 2^CNT_W-1, is cleared by reset only (not by flush), and counts in the flush cycle if the condition holds.
- Undefined: the port exists but is tied to 0 and no counter flops are synthesised.

Decomposition:
- Shared package pipe_pkg holds:
  - state encodings ST_EMPTY=2'd0, ST_FULL=2'd1, ST_SKID=2'd2;
  - the NOP constant MIPS_NOP=32'h0000_0000 used as RESET_VAL by instruction-carrying stages.
- One natural sub-module, pipe_dreg:
  - WIDTH-parametrised register with async active-low reset to RESET_VAL, synchronous clear (to RESET_VAL) and load enable.
  - Instantiated twice (main, skid).

Test Plan:
- Reset: hold rst_n=0 with in_valid=1, in_data=32'hDEAD_BEEF -> out_valid=0, in_ready=1, out_data=RESET_VAL. Release: first beat is out 1 cycle after accept.
- Streaming: out_ready=1, drive 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 on consecutive cycles; in_ready stays 1.
- Skid: FULL with 5, drop out_ready, present 6 -> SKID, in_ready=0 next cycle. Raise out_ready -> 5 then 6 delivered, no loss.
- Flush in SKID (holding 7,8) with in_valid=1, in_data=9 -> next cycle out_valid=0, in_ready=1, out_data=RESET_VAL; 7, 8 and 9 never appear.
- Async reset asserted mid-cycle in FULL -> outputs go to reset values before the next clk edge.
- With PIPE_STAGE_STALL_CNT_EN and CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 (saturated). Without the macro -> stall_cnt=0 throughout.
